// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction prefetch/alignment path.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package fetch_pkg;

    localparam int         HW_W   = 16;
    localparam logic [1:0] OPC_32 = 2'b11;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    // RVC encodings use every low opcode pair except 2'b11.
    function automatic logic is_compressed(input logic [HW_W-1:0] hw);
        return hw[1:0] != OPC_32;
    endfunction

endpackage

// File: rtl/rv_hw_fifo.sv
// Halfword circular queue: up to two pushes and two pops per cycle, synchronous clear.
// Latency: a push is visible at h0/h1 the cycle after it is written.
// Backpressure: none internally; the writer must check count before pushing.
module rv_hw_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH_HW = 8,
    localparam int PW       = $clog2(DEPTH_HW),
    localparam int CW       = PW + 1
) (
    input  logic            clk_i,
    input  logic            rst,
    input  logic            clear,
    input  logic [1:0]      push_n,
    input  logic [HW_W-1:0] push_d0,
    input  logic [HW_W-1:0] push_d1,
    input  logic [1:0]      pop_n,
    output logic [HW_W-1:0] h0,
    output logic [HW_W-1:0] h1,
    output logic [CW-1:0]   count
);

    logic [HW_W-1:0] mem [DEPTH_HW];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;

    // Pointers are PW bits wide, so the +1 wraps modulo DEPTH_HW for free.
    assign h0 = mem[rd_ptr];
    assign h1 = mem[rd_ptr + PW'(1)];

    // Storage: d0 lands at the write pointer, d1 in the slot after it.
    always_ff @(posedge clk_i) begin
        if (push_n != 2'd0) begin
            mem[wr_ptr] <= push_d0;
        end
        if (push_n == 2'd2) begin
            mem[wr_ptr + PW'(1)] <= push_d1;
        end
    end

    // Pointer and occupancy bookkeeping; clear empties the queue in one cycle.
    always_ff @(posedge clk_i) begin
        if (!rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push_n);
            rd_ptr <= rd_ptr + PW'(pop_n);
            count  <= count + CW'(push_n) - CW'(pop_n);
        end
    end

endmodule

// File: rtl/rv_fetch_align_buf.sv
// RV32IC fetch prefetch/align buffer: word fetches in, aligned 16/32-bit instructions out.
// Latency: gnt at N, rvalid at N+1 -> instr_valid_o at N+2 (empty queue, aligned PC).
// Backpressure: decode stalls via instr_ready_i; fetch requests only when 2 halfwords are free.
// Optional FETCH_STAT_EN adds stall_cnt_o, a saturating count of cycles without a valid instruction.
module rv_fetch_align_buf
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH_HW = 8,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0000)
) (
    input  logic            clk_i,
    input  logic            rst,
    input  logic            flush_i,
    input  logic [XLEN-1:0] flush_pc_i,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [31:0]     mem_rdata_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic            instr_compressed_o
`ifdef FETCH_STAT_EN
    ,
    output logic [31:0]     stall_cnt_o
`endif
);

    localparam int CW = $clog2(DEPTH_HW) + 1;

    fetch_state_t    state;
    fetch_state_t    state_nxt;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] head_pc;
    logic [XLEN-1:0] flush_hpc;
    logic            skip_lo;
    logic            armed;
    logic [CW-1:0]   count;
    logic [HW_W-1:0] h0;
    logic [HW_W-1:0] h1;
    logic [1:0]      push_n;
    logic [1:0]      pop_n;
    logic [HW_W-1:0] push_d0;
    logic            has_room;
    logic            req;
    logic            take_gnt;
    logic            take_data;
    logic            h0_c;
    logic            valid;
    logic            pop;
    logic            unused_bits;

    assign flush_hpc   = {flush_pc_i[XLEN-1:1], 1'b0};
    assign unused_bits = ^{flush_pc_i[0], fetch_pc[1:0]};

    // A word needs two free halfword slots; nothing else pushes while it is in flight.
    assign has_room  = ((CW+1)'(count) + (CW+1)'(2)) <= (CW+1)'(DEPTH_HW);
    // armed keeps the request low for the first cycle out of reset.
    assign req       = rst && armed && (state == FETCH) && has_room;
    assign take_gnt  = req && mem_gnt_i;
    assign take_data = rst && !flush_i && (state == WAIT) && mem_rvalid_i;

    assign h0_c  = is_compressed(h0);
    assign valid = rst && (((count != '0) && h0_c) || (count >= CW'(2)));
    assign pop   = valid && instr_ready_i && !flush_i;

    // After a redirect to an odd halfword, the low half of the first word is skipped.
    assign push_n  = take_data ? (skip_lo ? 2'd1 : 2'd2) : 2'd0;
    assign push_d0 = skip_lo ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    assign pop_n   = pop ? (h0_c ? 2'd1 : 2'd2) : 2'd0;

    rv_hw_fifo #(
        .DEPTH_HW (DEPTH_HW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst     (rst),
        .clear   (flush_i),
        .push_n  (push_n),
        .push_d0 (push_d0),
        .push_d1 (mem_rdata_i[31:16]),
        .pop_n   (pop_n),
        .h0      (h0),
        .h1      (h1),
        .count   (count)
    );

    // Fetch FSM state register.
    always_ff @(posedge clk_i) begin
        if (!rst) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a redirect turns any response still owed into one to be dropped.
    always_comb begin
        state_nxt = state;
        case (state)
            FETCH: begin
                if (take_gnt) begin
                    state_nxt = flush_i ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    state_nxt = FETCH;
                end else if (flush_i) begin
                    state_nxt = DROP;
                end
            end
            DROP: begin
                if (mem_rvalid_i) begin
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    // PC tracking: fetch address, head-of-queue PC and the skip-low-half flag.
    always_ff @(posedge clk_i) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            head_pc  <= RESET_PC;
            skip_lo  <= 1'b0;
            armed    <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (flush_i) begin
                fetch_pc <= flush_hpc;
                head_pc  <= flush_hpc;
                skip_lo  <= flush_pc_i[1];
            end else begin
                if (take_gnt) begin
                    fetch_pc <= {fetch_pc[XLEN-1:2] + (XLEN-2)'(1), 2'b00};
                end
                if (take_data) begin
                    skip_lo <= 1'b0;
                end
                if (pop) begin
                    head_pc <= head_pc + (h0_c ? XLEN'(2) : XLEN'(4));
                end
            end
        end
    end

    assign mem_req_o          = req;
    assign mem_addr_o         = {fetch_pc[XLEN-1:2], 2'b00};
    assign instr_valid_o      = valid;
    assign instr_o            = !valid ? 32'h0 : (h0_c ? {16'h0, h0} : {h1, h0});
    assign instr_compressed_o = valid && h0_c;
    assign instr_pc_o         = rst ? head_pc : RESET_PC;

`ifdef FETCH_STAT_EN
    logic [31:0] stall_cnt;

    // Saturating count of cycles out of reset with nothing to offer decode; flush leaves it alone.
    always_ff @(posedge clk_i) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (!valid && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt;
`endif

endmodule
